// File: rtl/router_pkg.sv
// router_pkg: header field layout, FSM states and destination decode shared by the input router
package router_pkg;

    localparam int DEST_LSB = 24;
    localparam int DEST_W   = 8;
    localparam int LEN_LSB  = 8;
    localparam int LEN_W    = 16;
    localparam int SEQ_LSB  = 0;
    localparam int SEQ_W    = 8;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    typedef struct packed {
        logic              legal;
        logic [DEST_W-1:0] port;
    } dest_t;

    // Destination IDs are 1-based on the wire; port index is dest-1, only meaningful when legal
    function automatic dest_t decode_dest(input logic [DEST_W-1:0] dest, input int num_ports);
        decode_dest.legal = (dest != '0) && (int'(dest) <= num_ports);
        decode_dest.port  = dest - DEST_W'(1);
    endfunction

endpackage

// File: rtl/router_out_stage.sv
// router_out_stage: registered write port towards one output buffer; data is zeroed when not writing
module router_out_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              sop,
    input  logic              last,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wr_en,
    output logic              out_sop,
    output logic              out_last
);

    // One-cycle strobe and qualifiers, all gated by the write so idle ports stay at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_wr_en <= 1'b0;
            out_sop   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_data  <= wr ? data : '0;
            out_wr_en <= wr;
            out_sop   <= wr && sop;
            out_last  <= wr && last;
        end
    end

endmodule

// File: rtl/input_router.sv
// input_router: steers each ingress packet to one of NUM_PORTS output buffers; DROP_STATS_EN enables drop_cnt
module input_router
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           in_word,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_PORTS-1:0]        out_full,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS-1:0]        out_wr_en,
    output logic [NUM_PORTS-1:0]        out_sop,
    output logic [NUM_PORTS-1:0]        out_last,
    output logic                        busy,
    output logic [15:0]                 drop_cnt
);

    state_t               state, state_n;
    logic [DEST_W-1:0]    cur_port, cur_port_n;
    logic [LEN_W-1:0]     remain, remain_n, len;
    dest_t                hdr;
    logic [NUM_PORTS-1:0] hdr_sel, cur_sel, wr;
    logic                 xfer, long_pkt, sop, last;

    assign hdr      = decode_dest(in_word[DEST_LSB +: DEST_W], NUM_PORTS);
    assign len      = in_word[LEN_LSB +: LEN_W];
    assign long_pkt = len > LEN_W'(1);

    // One-hot port selects for the incoming header and for the packet in flight
    always_comb begin
        hdr_sel = '0;
        cur_sel = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            hdr_sel[p] = hdr.legal && (hdr.port == DEST_W'(p));
            cur_sel[p] = cur_port == DEST_W'(p);
        end
    end

    // Reset forces the header rule so in_ready never depends on a stale mid-packet state
    assign in_ready = (rst || state == IDLE) ? !(|(out_full & hdr_sel)) :
                      (state == FWD)         ? !(|(out_full & cur_sel)) : 1'b1;
    assign xfer     = in_valid && in_ready && !rst;
    assign busy     = state != IDLE;

    // Next-state and write request for the accepted word
    always_comb begin
        state_n    = state;
        remain_n   = remain;
        cur_port_n = cur_port;
        wr         = '0;
        sop        = 1'b0;
        last       = 1'b0;
        if (xfer) begin
            case (state)
                IDLE: begin
                    wr   = hdr_sel;
                    sop  = 1'b1;
                    last = !long_pkt;
                    if (long_pkt) begin
                        remain_n   = len - LEN_W'(1);
                        cur_port_n = hdr.legal ? hdr.port : cur_port;
                        state_n    = hdr.legal ? FWD : DROP;
                    end
                end
                FWD: begin
                    wr       = cur_sel;
                    last     = remain == LEN_W'(1);
                    remain_n = remain - LEN_W'(1);
                    state_n  = (remain == LEN_W'(1)) ? IDLE : FWD;
                end
                default: begin
                    remain_n = remain - LEN_W'(1);
                    state_n  = (remain == LEN_W'(1)) ? IDLE : DROP;
                end
            endcase
        end
    end

    // Packet tracking state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            remain   <= '0;
            cur_port <= '0;
        end else begin
            state    <= state_n;
            remain   <= remain_n;
            cur_port <= cur_port_n;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        router_out_stage #(.DATA_W(DATA_W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr[g]),
            .sop      (sop),
            .last     (last),
            .data     (in_word),
            .out_data (out_data[g*DATA_W +: DATA_W]),
            .out_wr_en(out_wr_en[g]),
            .out_sop  (out_sop[g]),
            .out_last (out_last[g])
        );
    end

`ifdef DROP_STATS_EN
    logic [15:0] drop_q;
    logic        drop_inc;

    assign drop_inc = xfer && state == IDLE && !hdr.legal;
    assign drop_cnt = drop_q;

    // Saturating count of illegal headers accepted
    always_ff @(posedge clk) begin
        if (rst)
            drop_q <= '0;
        else if (drop_inc && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_input_router.sv
// tb_input_router: directed and random stimulus against a packet-level model of the router
module tb_input_router;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk, rst, in_valid, in_ready, busy;
    logic [W-1:0]   in_word;
    logic [N-1:0]   out_full, out_wr_en, out_sop, out_last;
    logic [N*W-1:0] out_data;
    logic [15:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    int left  = 0;
    int dst   = -1;
    int drops = 0;
    logic [N-1:0]   e_wr = '0, e_sop = '0, e_last = '0;
    logic [N*W-1:0] e_data = '0;
    int wr_count[N];

    input_router #(.NUM_PORTS(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .out_full(out_full), .out_data(out_data), .out_wr_en(out_wr_en), .out_sop(out_sop),
        .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] h(input int d, input int l, input int s);
        return {8'(d), 16'(l), 8'(s)};
    endfunction

    // Packet-level model: words left in the current packet and where they go (-1 = discard)
    always @(negedge clk) begin : model
        int d, l;
        logic legal, rdy;
        d = int'(in_word[31:24]);
        l = int'(in_word[23:8]);
        if (l == 0) l = 1;
        legal = d >= 1 && d <= N;
        if (rst || left == 0) rdy = legal ? !out_full[d-1] : 1'b1;
        else                  rdy = (dst >= 0) ? !out_full[dst] : 1'b1;
        chk("in_ready", in_ready, rdy);
        chk("out_wr_en", out_wr_en, e_wr);
        chk("out_sop", out_sop, e_sop);
        chk("out_last", out_last, e_last);
        chk("out_data", out_data, e_data);
        chk("busy", busy, left > 0);
`ifdef DROP_STATS_EN
        chk("drop_cnt", drop_cnt, 16'(drops));
`else
        chk("drop_cnt", drop_cnt, 0);
`endif
        for (int p = 0; p < N; p++) if (out_wr_en[p]) wr_count[p]++;
        e_wr = '0; e_sop = '0; e_last = '0; e_data = '0;
        if (rst) begin
            left = 0; dst = -1; drops = 0;
        end else if (in_valid && rdy) begin
            if (left == 0) begin
                if (legal) begin
                    e_wr[d-1] = 1'b1;
                    e_sop[d-1] = 1'b1;
                    e_last[d-1] = (l == 1);
                    e_data[(d-1)*W +: W] = in_word;
                end else if (drops < 65535) drops++;
                left = l - 1;
                dst = legal ? d - 1 : -1;
            end else begin
                if (dst >= 0) begin
                    e_wr[dst] = 1'b1;
                    e_last[dst] = (left == 1);
                    e_data[dst*W +: W] = in_word;
                end
                left--;
            end
        end
    end

    task automatic send(input logic [31:0] w, output int waits);
        in_word = w;
        in_valid = 1'b1;
        waits = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no acceptance expected acceptance of %h", w);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int p = 0; p < N; p++) wr_count[p] = 0;
    endtask

    initial begin
        int w, ws, stall;
        rst = 1; in_valid = 0; in_word = '0; out_full = '0;
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset wr_en", out_wr_en, 0);
        chk("reset data", out_data, 0);
        chk("reset busy", busy, 0);
        chk("reset drop_cnt", drop_cnt, 0);

        clear_counts();
        send(h(2, 3, 8'h11), w);
        send(32'hB0D1_0001, w);
        send(32'hB0D2_0002, w);
        settle();
        chk("t1 port1 writes", wr_count[1], 3);
        chk("t1 other writes", wr_count[0] + wr_count[2] + wr_count[3], 0);
        chk("t1 busy", busy, 0);

        clear_counts();
        send(h(1, 1, 8'h21), w);  ws = w;
        send(h(4, 2, 8'h22), w);  ws += w;
        send(32'hCAFE_0003, w);   ws += w;
        settle();
        chk("t2 waits", ws, 0);
        chk("t2 port0 writes", wr_count[0], 1);
        chk("t2 port3 writes", wr_count[3], 2);

        clear_counts();
        send(h(3, 4, 8'h31), w);
        send(32'h0000_0B01, w);
        in_word = 32'h0000_0B02;
        in_valid = 1'b1;
        out_full = 4'b0100;
        stall = 0;
        repeat (3) begin
            @(negedge clk);
            if (!in_ready) stall++;
            @(posedge clk);
            #1;
        end
        out_full = '0;
        send(32'h0000_0B02, w);
        chk("t3 resume waits", w, 0);
        send(32'h0000_0B03, w);
        settle();
        chk("t3 stall cycles", stall, 3);
        chk("t3 port2 writes", wr_count[2], 4);

        clear_counts();
        send(h(0, 5, 8'h41), w);
        for (int i = 0; i < 4; i++) send(32'h0700_0100 + 32'(i), w);
        send(h(7, 1, 8'h42), w);
        settle();
        chk("t4 writes", wr_count[0] + wr_count[1] + wr_count[2] + wr_count[3], 0);
        chk("t4 busy", busy, 0);
`ifdef DROP_STATS_EN
        chk("t4 drop_cnt", drop_cnt, 2);
`else
        chk("t4 drop_cnt", drop_cnt, 0);
`endif

        clear_counts();
        send(h(1, 4, 8'h51), w);
        send(32'h0000_0C01, w);
        rst = 1;
        @(posedge clk);
        #1;
        chk("t5 wr_en after rst", out_wr_en, 0);
        chk("t5 sop after rst", out_sop, 0);
        chk("t5 last after rst", out_last, 0);
        chk("t5 data after rst", out_data, 0);
        chk("t5 busy after rst", busy, 0);
        rst = 0;
        send(h(2, 1, 8'h52), w);
        settle();
        chk("t5 port0 writes", wr_count[0], 2);
        chk("t5 port1 writes", wr_count[1], 1);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_word = {8'($urandom_range(0, 5)), 16'($urandom_range(0, 4)), 8'($urandom)};
            out_full = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        end
        @(posedge clk);
        #1;
        rst = 0; in_valid = 0; out_full = '0;
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
